// File: rtl/fetch_ctrl_if.sv
// Instruction-fetch bus bundle: imem request/response channel plus the decode-side
// valid/ready presentation of fetched instructions.
interface fetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_instr;
  logic                  if_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: single-outstanding imem handshake, PC source arbitration
// (trap > redirect > sequential > hold) and stale-response discard after redirects.
module fetch_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 'h0000_1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_current_i,
  output logic [DATA_WIDTH-1:0] pc_next_o,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  trap_valid_i,
  input  logic [DATA_WIDTH-1:0] trap_vec_i,
  output logic                  misalign_exc_o,
  fetch_ctrl_if.master          bus
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHold} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] if_pc_q, if_instr_q;
  logic                  misalign_q, misalign_d;
  logic                  redirect_ok, event_w, capture;
  logic                  unused_trap_bits;

  assign unused_trap_bits = ^trap_vec_i[1:0];

  assign redirect_ok = redirect_valid_i && (redirect_pc_i[1:0] == 2'b00);
  // Only a trap or an aligned redirect moves the PC away from the outstanding fetch.
  assign event_w     = trap_valid_i || redirect_ok;
  assign capture     = (state_q == StWait) && bus.imem_rvalid && !event_w;
  assign misalign_d  = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00) && !trap_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (bus.imem_gnt) state_d = event_w ? StDrop : StWait;
      end
      StWait: begin
        if (bus.imem_rvalid)  state_d = event_w ? StReq : StHold;
        else if (event_w)     state_d = StDrop;
      end
      StDrop: begin
        if (bus.imem_rvalid) state_d = StReq;
      end
      StHold: begin
        if (event_w || bus.if_ready) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.imem_req  = (state_q == StReq);
    bus.imem_addr = pc_current_i;
    bus.if_valid  = (state_q == StHold);
    bus.if_pc     = if_pc_q;
    bus.if_instr  = if_instr_q;
  end

  always_comb begin
    if (trap_valid_i) begin
      pc_next_o = {trap_vec_i[DATA_WIDTH-1:2], 2'b00};
    end else if (redirect_ok) begin
      pc_next_o = redirect_pc_i;
    end else if ((state_q == StHold) && bus.if_ready) begin
      pc_next_o = pc_current_i + DATA_WIDTH'(4);
    end else begin
      pc_next_o = pc_current_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc_q    <= RESET_PC;
      if_instr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
      if (capture) begin
        if_pc_q    <= pc_current_i;
        if_instr_q <= bus.imem_rdata;
      end
    end
  end

  assign misalign_exc_o = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the fetch unit.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_reg, pc_next;
  logic        redirect_valid, trap_valid, misalign_exc;
  logic [31:0] redirect_pc, trap_vec;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.DATA_WIDTH(32)) bus ();

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_current_i    (pc_reg),
    .pc_next_o       (pc_next),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .trap_valid_i    (trap_valid),
    .trap_vec_i      (trap_vec),
    .misalign_exc_o  (misalign_exc),
    .bus             (bus)
  );

  // The core's PC register, fed by the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= RESET_PC;
    else        pc_reg <= pc_next;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what the fetch unit is doing, in transaction terms.
  bit          m_boot;     // first cycle after reset, no request yet
  bit          m_req;      // request being offered
  bit          m_out;      // granted request awaiting its response
  bit          m_stale;    // that response must be thrown away
  bit          m_valid;    // instruction being presented to decode
  bit          m_mis;
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic [31:0] seen_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_req   = 1'b0;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_pc    = RESET_PC;
    m_ifpc  = RESET_PC;
    m_instr = 32'h0;
  endtask

  task automatic drive_idle();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.if_ready    = 1'b0;
    trap_valid      = 1'b0;
    trap_vec        = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
  endtask

  // One clock cycle; entered and left on a falling edge.
  task automatic cyc(input bit gnt, input bit rvm, input logic [31:0] rdata, input bit rdy,
                     input bit trap, input logic [31:0] tvec, input bit redir,
                     input logic [31:0] rpc);
    bit          ev;
    logic [31:0] pcn;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rvm;
    bus.imem_rdata  = rdata;
    bus.if_ready    = rdy;
    trap_valid      = trap;
    trap_vec        = tvec;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    #1;
    ev = trap || (redir && rpc[1:0] == 2'b00);
    if (trap)                             pcn = tvec & 32'hFFFF_FFFC;
    else if (redir && rpc[1:0] == 2'b00)  pcn = rpc;
    else if (m_valid && rdy)              pcn = m_pc + 32'd4;
    else                                  pcn = m_pc;

    chk("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
    chk("if_pc", bus.if_pc, m_ifpc);
    chk("if_instr", bus.if_instr, m_instr);
    chk("misalign_exc", 32'(misalign_exc), 32'(m_mis));
    chk("pc_current", pc_reg, m_pc);
    chk("pc_next", pc_next, pcn);
    seen_next = pc_next;

    m_mis = redir && (rpc[1:0] != 2'b00) && !trap;
    if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
    end else if (m_req) begin
      if (gnt) begin
        m_req   = 1'b0;
        m_out   = 1'b1;
        m_stale = ev;
      end
    end else if (m_out) begin
      if (rvm) begin
        m_out = 1'b0;
        if (m_stale || ev) begin
          m_req = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_ifpc  = m_pc;
          m_instr = rdata;
        end
        m_stale = 1'b0;
      end else if (ev) begin
        m_stale = 1'b1;
      end
    end else if (m_valid) begin
      if (ev || rdy) begin
        m_valid = 1'b0;
        m_req   = 1'b1;
      end
    end
    m_pc = pcn;
    @(negedge clk);
  endtask

  // Well-behaved memory: always grants, answers the cycle after the grant.
  task automatic auto(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, m_out, 32'h0000_0013, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst if_pc", bus.if_pc, RESET_PC);
    chk("rst if_instr", bus.if_instr, 32'h0);
    chk("rst misalign", 32'(misalign_exc), 32'h0);
    chk("rst pc_current", pc_reg, RESET_PC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Sequential fetch from the boot PC.
    chk("boot no req", 32'(bus.imem_req), 32'h0);
    auto(1, 1'b1);
    chk("first addr", bus.imem_addr, 32'h0000_1000);
    chk("first req", 32'(bus.imem_req), 32'h1);
    auto(2, 1'b1);
    chk("hold valid", 32'(bus.if_valid), 32'h1);
    chk("hold pc", bus.if_pc, 32'h0000_1000);
    chk("hold instr", bus.if_instr, 32'h0000_0013);
    auto(1, 1'b1);
    chk("seq next", seen_next, 32'h0000_1004);
    chk("second addr", bus.imem_addr, 32'h0000_1004);
    auto(3, 1'b1);
    chk("third addr", bus.imem_addr, 32'h0000_1008);

    // Decode backpressure.
    auto(2, 1'b0);
    auto(5, 1'b0);
    chk("bp valid", 32'(bus.if_valid), 32'h1);
    chk("bp pc", bus.if_pc, 32'h0000_1008);
    chk("bp no req", 32'(bus.imem_req), 32'h0);
    chk("bp pc hold", pc_reg, 32'h0000_1008);
    auto(1, 1'b1);
    chk("bp release next", seen_next, 32'h0000_100C);
    chk("bp release addr", bus.imem_addr, 32'h0000_100C);

    // Redirect while waiting: response is dropped.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
    chk("redir next", seen_next, 32'h0000_2000);
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("drop no valid", 32'(bus.if_valid), 32'h0);
    chk("redir addr", bus.imem_addr, 32'h0000_2000);
    auto(2, 1'b1);
    chk("redir if_pc", bus.if_pc, 32'h0000_2000);

    // Trap beats redirect.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103, 1'b1, 32'h0000_3000);
    chk("trap next", seen_next, 32'h0000_0100);
    chk("trap no mis", 32'(misalign_exc), 32'h0);
    chk("trap addr", bus.imem_addr, 32'h0000_0100);

    // Misaligned redirect.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_2002);
    chk("mis pc hold", seen_next, 32'h0000_0100);
    chk("mis pulse", 32'(misalign_exc), 32'h1);
    auto(1, 1'b1);
    chk("mis one cycle", 32'(misalign_exc), 32'h0);
    auto(1, 1'b1);
    chk("mis if_pc", bus.if_pc, 32'h0000_0100);
    auto(1, 1'b1);
    chk("mis seq next", seen_next, 32'h0000_0104);

    // PC wrap.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap addr", bus.imem_addr, 32'hFFFF_FFFC);
    auto(2, 1'b1);
    chk("wrap if_pc", bus.if_pc, 32'hFFFF_FFFC);
    auto(1, 1'b1);
    chk("wrap next", seen_next, 32'h0000_0000);
    chk("wrap addr0", bus.imem_addr, 32'h0000_0000);

    // Reset during WAIT; a late response in IDLE is ignored.
    auto(1, 1'b1);
    do_reset();
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("post-rst addr", bus.imem_addr, 32'h0000_1000);
    chk("post-rst no valid", 32'(bus.if_valid), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        bit          g, rv, rd, tr, rdr;
        logic [31:0] tv, rp;
        g   = ($urandom_range(0, 2) != 0);
        rv  = m_out && ($urandom_range(0, 2) == 0);
        rd  = ($urandom_range(0, 3) != 0);
        tr  = ($urandom_range(0, 19) == 0);
        tv  = $urandom;
        rdr = ($urandom_range(0, 11) == 0);
        rp  = $urandom;
        if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
        cyc(g, rv, $urandom, rd, tr, tv, rdr, rp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
